fifo_share_ctrl: RTL and testbench

Controller that shares one 8-entry, 8-bit FIFO buffer between four write requesters and one downstream consumer. It round-robin arbitrates the requesters onto the FIFO write port and schedules FIFO reads into a valid/ready output. It never issues a read and a write in the same cycle, so no operation is silently dropped. It tracks occupancy itself, supports a one-cycle flush, and sits between the producer blocks and the FIFO instance.

---
 rtl/fifo_share_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fifo_share_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl
// Shares one FIFO between N_REQ write requesters and a single valid/ready
// consumer. Requesters are served round-robin onto the FIFO write port and
// FIFO reads feed a registered output stage. A read and a write are never
// issued in the same cycle. When both are wanted, a priority bit alternates
// between them.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              one-cycle pulse that discards FIFO contents
//   req_valid_i          per-requester data valid
//   req_data_i           requester i data in [i*DATA_W +: DATA_W]
//   req_ready_o          one-hot, marks the requester written this cycle
//   grant_id_o           index of the last granted requester
//   fifo_en_o            FIFO enable (always 1)
//   fifo_rst_o           FIFO reset (reset or flush state)
//   fifo_wr_o, fifo_rd_o FIFO strobes, mutually exclusive
//   fifo_din_o           selected requester data
//   fifo_full_i          FIFO full flag (extra guard)
//   fifo_empty_i         FIFO empty flag (extra guard)
//   fifo_dout_i          FIFO registered read data
//   out_valid_o          output stage valid
//   out_data_o           output stage data
//   out_ready_i          consumer ready
module fifo_share_ctrl #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int GW        = $clog2(N_REQ),
    localparam int OW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [GW-1:0]           grant_id_o,
    output logic                    fifo_en_o,
    output logic                    fifo_rst_o,
    output logic                    fifo_wr_o,
    output logic                    fifo_rd_o,
    output logic [DATA_W-1:0]       fifo_din_o,
    input  logic                    fifo_full_i,
    input  logic                    fifo_empty_i,
    input  logic [DATA_W-1:0]       fifo_dout_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    input  logic                    out_ready_i
);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          outValid_q, outValid_d;
    logic [GW-1:0] grantId_q, grantId_d;
    logic          rdPri_q, rdPri_d;

    logic          isRun;
    logic          wrCand;
    logic          rdCand;
    logic          doWr;
    logic          doRd;
    logic [GW-1:0] winner;

    // Round-robin search starting just after the last grant, wrapping
    // around. Indices are kept below N_REQ so non-power-of-two counts work.
    always_comb begin
        int   idx;
        logic found;
        winner = grantId_q;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = int'(grantId_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid_i[GW'(idx)]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Candidate detection and conflict resolution. The occupancy counter is
    // the primary guard; the FIFO flags only back it up.
    always_comb begin
        isRun  = (state_q == RUN) && !rst_i;
        wrCand = isRun && (|req_valid_i) && (occ_q < OW'(FIFO_DEPTH)) && !fifo_full_i;
        rdCand = isRun && (occ_q != '0) && !fifo_empty_i && (!outValid_q || out_ready_i);
        doWr   = wrCand && (!rdCand || !rdPri_q);
        doRd   = rdCand && (!wrCand || rdPri_q);
    end

    always_comb begin
        req_ready_o = '0;
        if (doWr) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign fifo_din_o  = req_data_i[winner*DATA_W +: DATA_W];
    assign fifo_wr_o   = doWr;
    assign fifo_rd_o   = doRd;
    assign fifo_en_o   = 1'b1;
    assign fifo_rst_o  = rst_i || (state_q == FLUSH);
    assign grant_id_o  = grantId_q;
    assign out_valid_o = outValid_q;
    assign out_data_o  = fifo_dout_i;

    // Next-state logic. A read always reloads the output stage, even when
    // the consumer takes the old word in the same cycle.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        outValid_d = outValid_q;
        grantId_d  = grantId_q;
        rdPri_d    = rdPri_q;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end
                if (doWr) begin
                    occ_d     = occ_q + OW'(1);
                    grantId_d = winner;
                end else if (doRd) begin
                    occ_d = occ_q - OW'(1);
                end
                if (doRd) begin
                    outValid_d = 1'b1;
                end else if (outValid_q && out_ready_i) begin
                    outValid_d = 1'b0;
                end
                if (wrCand && rdCand) begin
                    rdPri_d = ~rdPri_q;
                end
            end
            FLUSH: begin
                state_d    = RUN;
                occ_d      = '0;
                outValid_d = 1'b0;
                rdPri_d    = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    // State registers. The grant pointer resets to the last index so that
    // requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            occ_q      <= '0;
            outValid_q <= 1'b0;
            grantId_q  <= GW'(N_REQ - 1);
            rdPri_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            outValid_q <= outValid_d;
            grantId_q  <= grantId_d;
            rdPri_q    <= rdPri_d;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Testbench for fifo_share_ctrl. Includes a small behavioural 8x8 FIFO
// that the controller drives. It applies directed vectors and compares them
// against hand-computed expectations.
module tb_fifo_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqReady;
    logic [1:0]  grantId;
    logic        fifoEn, fifoRst, fifoWr, fifoRd;
    logic [7:0]  fifoDin;
    logic        fifoFull, fifoEmpty;
    logic [7:0]  fifoDout;
    logic        outValid;
    logic [7:0]  outData;
    logic        outReady;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_share_ctrl #(.N_REQ(4), .DATA_W(8), .FIFO_DEPTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_valid_i (reqValid),
        .req_data_i  (reqData),
        .req_ready_o (reqReady),
        .grant_id_o  (grantId),
        .fifo_en_o   (fifoEn),
        .fifo_rst_o  (fifoRst),
        .fifo_wr_o   (fifoWr),
        .fifo_rd_o   (fifoRd),
        .fifo_din_o  (fifoDin),
        .fifo_full_i (fifoFull),
        .fifo_empty_i(fifoEmpty),
        .fifo_dout_i (fifoDout),
        .out_valid_o (outValid),
        .out_data_o  (outData),
        .out_ready_i (outReady)
    );

    // Behavioural FIFO with registered read data and synchronous reset
    logic [7:0] mem [8];
    int wp = 0;
    int rp = 0;
    int cnt = 0;

    always @(posedge clk) begin
        if (fifoRst) begin
            wp  <= 0;
            rp  <= 0;
            cnt <= 0;
        end else if (fifoWr) begin
            mem[wp] <= fifoDin;
            wp      <= (wp + 1) % 8;
            cnt     <= cnt + 1;
        end else if (fifoRd) begin
            fifoDout <= mem[rp];
            rp       <= (rp + 1) % 8;
            cnt      <= cnt - 1;
        end
    end

    assign fifoFull  = (cnt == 8);
    assign fifoEmpty = (cnt == 0);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic fl, input logic [3:0] v, input logic ordy);
        rst      = r;
        flush    = fl;
        reqValid = v;
        outReady = ordy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expReady [11] = '{1, 2, 0, 4, 8, 1, 2, 4, 8, 1, 0};
        int expDrain [7]  = '{'h12, 'h13, 'h10, 'h11, 'h12, 'h13, 'h10};
        int budget;
        logic prevWr;

        reqData = {8'h13, 8'h12, 8'h11, 8'h10};
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b0);
        checkOutput("rstReady", 32'(reqReady), 0);
        checkOutput("rstFifoRst", 32'(fifoRst), 1);
        checkOutput("rstFifoEn", 32'(fifoEn), 1);
        checkOutput("rstWr", 32'(fifoWr), 0);
        checkOutput("rstRd", 32'(fifoRd), 0);
        tick();
        tick();
        checkOutput("rstGrant", 32'(grantId), 3);
        checkOutput("rstOutValid", 32'(outValid), 0);
        checkOutput("rstOcc", 32'(dut.occ_q), 0);
        checkOutput("rstReady2", 32'(reqReady), 0);

        // Release reset with everyone requesting, consumer stalled
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0);
        checkOutput("firstReady", 32'(reqReady), 1);
        checkOutput("firstDin", 32'(fifoDin), 'h10);
        checkOutput("firstFifoRst", 32'(fifoRst), 0);
        for (int c = 0; c < 11; c++) begin
            checkOutput($sformatf("rrReady%0d", c), 32'(reqReady), 32'(expReady[c]));
            checkOutput($sformatf("rrWr%0d", c), 32'(fifoWr), (expReady[c] != 0) ? 1 : 0);
            checkOutput($sformatf("rrRd%0d", c), 32'(fifoRd), (c == 2) ? 1 : 0);
            tick();
        end
        checkOutput("fullOcc", 32'(dut.occ_q), 8);
        checkOutput("fullOutValid", 32'(outValid), 1);
        checkOutput("fullOutData", 32'(outData), 'h10);
        checkOutput("fullGrant", 32'(grantId), 0);

        // Consumer stalled: output holds, no read
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("holdData", 32'(outData), 'h10);
            checkOutput("holdRd", 32'(fifoRd), 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("pulseRd", 32'(fifoRd), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("pulseValid", 32'(outValid), 1);
        checkOutput("pulseData", 32'(outData), 'h11);
        checkOutput("pulseOcc", 32'(dut.occ_q), 7);
        checkOutput("pulseRdOff", 32'(fifoRd), 0);

        // Drain the rest at one word per cycle
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("drainRd%0d", i), 32'(fifoRd), 1);
            tick();
            checkOutput($sformatf("drainData%0d", i), 32'(outData), 32'(expDrain[i]));
            checkOutput($sformatf("drainValid%0d", i), 32'(outValid), 1);
        end
        checkOutput("emptyRd", 32'(fifoRd), 0);
        checkOutput("emptyOcc", 32'(dut.occ_q), 0);
        tick();
        checkOutput("emptyValid", 32'(outValid), 0);

        // Requester 2 alone: fill to 3, then alternate write/read
        reqData = {8'h13, 8'h55, 8'h11, 8'h10};
        applyStimulus(1'b0, 1'b0, 4'b0100, 1'b0);
        budget = 0;
        while (dut.occ_q != 3 && budget < 20) begin
            tick();
            budget++;
        end
        checkOutput("fillTo3", 32'(dut.occ_q), 3);
        applyStimulus(1'b0, 1'b0, 4'b0100, 1'b1);
        prevWr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("altOneOp%0d", i), 32'(fifoWr) + 32'(fifoRd), 1);
            if (i > 0) begin
                checkOutput($sformatf("altToggle%0d", i), 32'(fifoWr), 32'(!prevWr));
            end
            checkOutput($sformatf("altOcc%0d", i), 32'(dut.occ_q >= 3 && dut.occ_q <= 4), 1);
            if (fifoWr) begin
                checkOutput($sformatf("altReady%0d", i), 32'(reqReady), 4);
                checkOutput($sformatf("altDin%0d", i), 32'(fifoDin), 'h55);
            end
            prevWr = fifoWr;
            tick();
        end

        // Build up to occ 5 with a held output word, then flush
        applyStimulus(1'b0, 1'b0, 4'b0100, 1'b0);
        budget = 0;
        while (!(dut.occ_q == 5 && outValid) && budget < 20) begin
            tick();
            budget++;
        end
        checkOutput("preFlushOcc", 32'(dut.occ_q), 5);
        checkOutput("preFlushValid", 32'(outValid), 1);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
        checkOutput("flushRst", 32'(fifoRst), 1);
        checkOutput("flushReady", 32'(reqReady), 0);
        checkOutput("flushWr", 32'(fifoWr), 0);
        checkOutput("flushRd", 32'(fifoRd), 0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0);
        checkOutput("postFlushOcc", 32'(dut.occ_q), 0);
        checkOutput("postFlushValid", 32'(outValid), 0);
        checkOutput("postFlushRun", 32'(fifoRst), 0);
        checkOutput("postFlushReady", 32'(reqReady), 8);
        tick();

        // Reset and flush together: reset wins, back in RUN afterwards
        applyStimulus(1'b1, 1'b1, 4'hF, 1'b0);
        checkOutput("rstFlushReady", 32'(reqReady), 0);
        checkOutput("rstFlushFifoRst", 32'(fifoRst), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0);
        checkOutput("afterRstRun", 32'(fifoRst), 0);
        checkOutput("afterRstGrant", 32'(grantId), 3);
        checkOutput("afterRstOcc", 32'(dut.occ_q), 0);
        checkOutput("afterRstReady", 32'(reqReady), 1);
        checkOutput("afterRstValid", 32'(outValid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
